step_clock_ctrl: RTL and testbench

STEP_CLOCK_CTRL -- requirements
Module: step_clock_ctrl

---
 rtl/step_clock_pkg.sv | 16 +
 rtl/step_clock_ctrl_debounce.sv | 45 ++++
 rtl/step_clock_ctrl.sv | 141 ++++++++++++++
 tb/tb_step_clock_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/step_clock_pkg.sv
// rtl/step_clock_pkg.sv - shared state type and parameter defaults for step_clock_ctrl
package step_clock_pkg;

   // Default synchronizer depth for every asynchronous input
   localparam int SYNC_STAGES_DEFAULT     = 2;
   // 10 ms of stable button level at a 27 MHz clk
   localparam int DEBOUNCE_CYCLES_DEFAULT = 270_000;

   // Operating mode of the clock-enable generator
   typedef enum logic [1:0] {
      ST_HALT       = 2'd0,
      ST_RUN        = 2'd1,
      ST_STEP_ARMED = 2'd2
   } state_t;

endpackage

// File: rtl/step_clock_ctrl_debounce.sv
// rtl/step_clock_ctrl_debounce.sv - btn_debounce: accepts a new button level after a stable run
module btn_debounce
   import step_clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_level,
   output logic o_level,
   output logic o_rise
);

   // Counter only has to reach DEBOUNCE_CYCLES-1; the acceptance happens on that cycle
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_level;
   logic          r_rise;
   logic [CW-1:0] r_cnt;

   // Count consecutive mismatching samples; any agreeing sample restarts the count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_rise <= 1'b0;
         if (i_level == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= i_level;
            r_rise  <= i_level;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;

endmodule

// File: rtl/step_clock_ctrl.sv
// rtl/step_clock_ctrl.sv - free-run / single-step CPU clock enable; STEP_CLOCK_CYCLE_COUNT_EN adds a cycle counter
module step_clock_ctrl
   import step_clock_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pulse_in,
   input  logic        run_sw,
   input  logic        step_btn,
   output logic        cpu_en,
   output logic        halted,
   output logic [31:0] cycle_cnt
);

   logic [SYNC_STAGES-1:0] r_pulse_sync;
   logic [SYNC_STAGES-1:0] r_run_sync;
   logic [SYNC_STAGES-1:0] r_btn_sync;
   logic [SYNC_STAGES-1:0] r_fill;
   logic                   r_pulse_prev;
   logic                   r_tick;
   state_t                 r_state;

   logic w_pulse_s;
   logic w_run_s;
   logic w_btn_s;
   logic w_sync_valid;
   logic w_btn_level;
   logic w_btn_rise;
   logic w_step_req;

   // Synchronizer chains; r_fill marks when the chain outputs carry real samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pulse_sync <= '0;
         r_run_sync   <= '0;
         r_btn_sync   <= '0;
         r_fill       <= '0;
      end else begin
         r_pulse_sync <= {r_pulse_sync[SYNC_STAGES-2:0], pulse_in};
         r_run_sync   <= {r_run_sync[SYNC_STAGES-2:0], run_sw};
         r_btn_sync   <= {r_btn_sync[SYNC_STAGES-2:0], step_btn};
         r_fill       <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign w_pulse_s    = r_pulse_sync[SYNC_STAGES-1];
   assign w_run_s      = r_run_sync[SYNC_STAGES-1];
   assign w_btn_s      = r_btn_sync[SYNC_STAGES-1];
   assign w_sync_valid = r_fill[SYNC_STAGES-1];

   // Registered rising-edge detect; history held high until the chain holds real
   // samples so a pulse_in already high at reset release never counts as an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pulse_prev <= 1'b1;
         r_tick       <= 1'b0;
      end else begin
         r_pulse_prev <= w_sync_valid ? w_pulse_s : 1'b1;
         r_tick       <= w_sync_valid & w_pulse_s & ~r_pulse_prev;
      end
   end

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_level (w_btn_s),
      .o_level (w_btn_level),
      .o_rise  (w_btn_rise)
   );

   // The rise pulse is only honoured while the debounced level agrees with it
   assign w_step_req = w_btn_rise & w_btn_level;

   // Mode FSM: decides which ticks become CPU enables; halted follows the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_HALT;
         cpu_en  <= 1'b0;
         halted  <= 1'b1;
      end else begin
         cpu_en <= 1'b0;
         case (r_state)
            ST_HALT: begin
               if (w_run_s) begin
                  r_state <= ST_RUN;
                  halted  <= 1'b0;
               end else if (w_step_req) begin
                  r_state <= ST_STEP_ARMED;
                  halted  <= 1'b1;
               end
            end
            ST_RUN: begin
               // A tick coinciding with run_sw dropping is still delivered
               cpu_en <= r_tick;
               if (!w_run_s) begin
                  r_state <= ST_HALT;
                  halted  <= 1'b1;
               end
            end
            ST_STEP_ARMED: begin
               if (w_run_s) begin
                  cpu_en  <= r_tick;
                  r_state <= ST_RUN;
                  halted  <= 1'b0;
               end else if (r_tick) begin
                  cpu_en  <= 1'b1;
                  r_state <= ST_HALT;
                  halted  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_HALT;
               halted  <= 1'b1;
            end
         endcase
      end
   end

`ifdef STEP_CLOCK_CYCLE_COUNT_EN
   logic [31:0] r_cycle_cnt;

   // Count issued enables one cycle after each pulse; wraps naturally at 2^32
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycle_cnt <= '0;
      end else if (cpu_en) begin
         r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
   end

   assign cycle_cnt = r_cycle_cnt;
`else
   assign cycle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_step_clock_ctrl.sv
// tb/tb_step_clock_ctrl.sv - self-checking bench for step_clock_ctrl (history-based model plus directed checks)
module tb_step_clock_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pulse_in = 1'b1;
   logic        run_sw = 1'b1;
   logic        step_btn = 1'b0;
   logic        cpu_en;
   logic        halted;
   logic [31:0] cycle_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int en_count = 0;
   int en_cyc[$];

   step_clock_ctrl #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pulse_in  (pulse_in),
      .run_sw    (run_sw),
      .step_btn  (step_btn),
      .cpu_en    (cpu_en),
      .halted    (halted),
      .cycle_cnt (cycle_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Inputs sampled at every clk edge since reset; outputs derived from the rules:
   // tick = pulse rise seen 3 edges earlier, run_sw seen 2 edges late, button
   // accepted after 4 consecutive differing synchronized samples.
   bit pq[$];
   bit rq[$];
   bit bq[$];
   int          m_mode = 0;   // 0 halt, 1 run, 2 step armed
   bit          m_en   = 1'b0;
   bit          m_halt = 1'b1;
   bit          m_lvl  = 1'b0;
   bit          m_req  = 1'b0;
   logic [31:0] m_cnt  = 32'd0;
`ifdef STEP_CLOCK_CYCLE_COUNT_EN
   bit          do_preload = 1'b0;
`endif

   function automatic bit P(int j);
      if (j < 1) return 1'b1;
      return pq[j-1];
   endfunction
   function automatic bit R(int j);
      if (j < 1) return 1'b0;
      return rq[j-1];
   endfunction
   function automatic bit B(int j);
      if (j < 1) return 1'b0;
      return bq[j-1];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pq.delete(); rq.delete(); bq.delete();
         m_mode = 0; m_en = 1'b0; m_halt = 1'b1;
         m_lvl = 1'b0; m_req = 1'b0; m_cnt = 32'd0;
      end else begin
         int  k;
         bit  tick, run, req;
`ifdef STEP_CLOCK_CYCLE_COUNT_EN
         if (do_preload) m_cnt = 32'hFFFF_FFFF;
         else if (m_en)  m_cnt = m_cnt + 32'd1;
`endif
         pq.push_back(pulse_in);
         rq.push_back(run_sw);
         bq.push_back(step_btn);
         k    = pq.size();
         tick = P(k-3) && !P(k-4);
         run  = R(k-2);
         req  = m_req;
         m_req = 1'b0;
         if (B(k-2) != m_lvl && B(k-3) != m_lvl && B(k-4) != m_lvl && B(k-5) != m_lvl) begin
            m_lvl = !m_lvl;
            m_req = m_lvl;
         end
         m_en = 1'b0;
         case (m_mode)
            0: if (run) m_mode = 1; else if (req) m_mode = 2;
            1: begin m_en = tick; if (!run) m_mode = 0; end
            default: begin
               if (run) begin m_en = tick; m_mode = 1; end
               else if (tick) begin m_en = 1'b1; m_mode = 0; end
            end
         endcase
         m_halt = (m_mode != 1);
      end
   end

   // Per-cycle comparison, 2 time units after the active edge
   always begin
      @(posedge clk);
      #2;
      cyc++;
      chk("model_cpu_en", {31'd0, cpu_en}, {31'd0, m_en});
      chk("model_halted", {31'd0, halted}, {31'd0, m_halt});
      chk("model_cycle_cnt", cycle_cnt, m_cnt);
      if (cpu_en === 1'b1) begin
         en_count++;
         en_cyc.push_back(cyc);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic period(input int n);
      repeat (n) begin
         pulse_in = 1'b1; wait_n(10);
         pulse_in = 1'b0; wait_n(10);
      end
   endtask

   task automatic press(input int hold);
      step_btn = 1'b1; wait_n(hold);
      step_btn = 1'b0; wait_n(hold);
   endtask

   initial begin
      int base, rise, lat;

      // Reset with pulse_in high and free-run selected
      wait_n(3);
      chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd1);
      chk("rst_cycle_cnt", cycle_cnt, 32'd0);
      rst = 1'b0;
      wait_n(20);
      chk("no_tick_from_high_at_release", en_count, 32'd0);
      chk("run_not_halted", {31'd0, halted}, 32'd0);

      // First real edge: low then high
      pulse_in = 1'b0; wait_n(10);
      base = en_count;
      pulse_in = 1'b1; rise = cyc;
      wait_n(10);
      chk("first_tick_count", en_count - base, 32'd1);
      lat = (en_cyc.size() > 0) ? en_cyc[$] - (rise + 1) : -1;
      chk("rise_to_en_latency", lat, 32'd3);

      // Free run, pulse_in period 20
      en_cyc.delete();
      base = en_count;
      repeat (6) begin
         pulse_in = 1'b0; wait_n(10);
         pulse_in = 1'b1; wait_n(10);
      end
      chk("run_pulse_count", en_count - base, 32'd6);
      for (int i = 1; i < en_cyc.size(); i++)
         chk("run_period", en_cyc[i] - en_cyc[i-1], 32'd20);

      // Halt; short glitch must not step
      run_sw = 1'b0; pulse_in = 1'b0; wait_n(10);
      chk("halt_halted", {31'd0, halted}, 32'd1);
      step_btn = 1'b1; wait_n(3); step_btn = 1'b0; wait_n(8);
      base = en_count;
      period(2);
      chk("glitch_no_step", en_count - base, 32'd0);

      // Bouncing press 1,0,1 then held
      step_btn = 1'b1; wait_n(1);
      step_btn = 1'b0; wait_n(1);
      step_btn = 1'b1; wait_n(10);
      step_btn = 1'b0; wait_n(10);
      base = en_count;
      period(2);
      chk("step_one_en", en_count - base, 32'd1);
      chk("step_back_halted", {31'd0, halted}, 32'd1);

      // Two presses before any tick: still one enable
      press(8); press(8);
      base = en_count;
      period(2);
      chk("double_press_one_en", en_count - base, 32'd1);

      // Tick and run_sw falling in the same cycle
      run_sw = 1'b1; wait_n(6);
      base = en_count;
      pulse_in = 1'b1; wait_n(1);
      run_sw = 1'b0; wait_n(9);
      pulse_in = 1'b0; wait_n(10);
      chk("run_drop_tick_en", en_count - base, 32'd1);
      chk("run_drop_halted", {31'd0, halted}, 32'd1);
      period(1);
      chk("run_drop_then_none", en_count - base, 32'd1);

      // Armed step with run_sw rising in the tick cycle
      press(8);
      base = en_count;
      pulse_in = 1'b1; wait_n(1);
      run_sw = 1'b1; wait_n(9);
      chk("armed_to_run_one_en", en_count - base, 32'd1);
      chk("armed_to_run_halted", {31'd0, halted}, 32'd0);
      pulse_in = 1'b0; run_sw = 1'b0; wait_n(10);

      // Reset while armed abandons the step
      press(8);
      rst = 1'b1; wait_n(3);
      chk("rst_mid_cpu_en", {31'd0, cpu_en}, 32'd0);
      rst = 1'b0; wait_n(4);
      base = en_count;
      period(2);
      chk("rst_drops_armed", en_count - base, 32'd0);
      chk("rst_drops_halted", {31'd0, halted}, 32'd1);

`ifdef STEP_CLOCK_CYCLE_COUNT_EN
      // Preload counter to all ones, next enable wraps it
      force dut.r_cycle_cnt = 32'hFFFF_FFFF;
      do_preload = 1'b1;
      wait_n(1);
      release dut.r_cycle_cnt;
      do_preload = 1'b0;
      chk("cnt_preload", cycle_cnt, 32'hFFFF_FFFF);
      run_sw = 1'b1; wait_n(4);
      base = en_count;
      pulse_in = 1'b1;
      for (int i = 0; i < 20 && en_count == base; i++) wait_n(1);
      chk("cnt_wrap_en_seen", en_count - base, 32'd1);
      wait_n(1);
      chk("cnt_wrap_zero", cycle_cnt, 32'd0);
      pulse_in = 1'b0; run_sw = 1'b0; wait_n(10);
`else
      chk("cnt_const_zero", cycle_cnt, 32'd0);
`endif

      wait_n(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
